// File: rtl/booth_seq_mult.sv
// booth_seq_mult: iterative signed WxW radix-4 Booth multiplier time-sharing one booth_pp (latency PIPE).
// Optional BOOTH_SEQ_EARLY_TERM_EN: stop issuing digits once the remaining multiplier bits are pure sign.

module booth_pp #(
    parameter int unsigned W    = 8,
    parameter int unsigned PIPE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] y,
    input  logic [2:0]   booth_bits,
    output logic [W:0]   pp,
    output logic         cpl
);
    logic [W:0] y1;
    logic [W:0] y2;
    logic [W:0] pp_c;
    logic       cpl_c;

    assign y1 = {y[W-1], y};
    assign y2 = {y, 1'b0};

    // Negative multiples are returned as one's complement; cpl supplies the +1.
    always_comb begin
        pp_c  = '0;
        cpl_c = 1'b0;
        case (booth_bits)
            3'b001, 3'b010: pp_c = y1;
            3'b011:         pp_c = y2;
            3'b100: begin
                pp_c  = ~y2;
                cpl_c = 1'b1;
            end
            3'b101, 3'b110: begin
                pp_c  = ~y1;
                cpl_c = 1'b1;
            end
            default: ;
        endcase
    end

    generate
        if (PIPE == 0) begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = &{clk, rst};
            assign pp  = pp_c;
            assign cpl = cpl_c;
        end else begin : g_pipe
            logic [W:0] pp_q  [PIPE];
            logic       cpl_q [PIPE];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int unsigned i = 0; i < PIPE; i++) begin
                        pp_q[i]  <= '0;
                        cpl_q[i] <= 1'b0;
                    end
                end else begin
                    pp_q[0]  <= pp_c;
                    cpl_q[0] <= cpl_c;
                    for (int unsigned i = 1; i < PIPE; i++) begin
                        pp_q[i]  <= pp_q[i-1];
                        cpl_q[i] <= cpl_q[i-1];
                    end
                end
            end
            assign pp  = pp_q[PIPE-1];
            assign cpl = cpl_q[PIPE-1];
        end
    endgenerate
endmodule

module booth_seq_mult #(
    parameter int unsigned W    = 8,
    parameter int unsigned PIPE = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic           busy
);
    localparam int unsigned ND = W / 2;
    localparam int unsigned IW = $clog2(ND);
    localparam int unsigned BW = $clog2(W + 1);
    localparam logic [IW-1:0] LAST = IW'(ND - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t         state, state_nx;
    logic           live;
    logic [W-1:0]   a_q;
    logic [W:0]     b_ext;
    logic [IW-1:0]  cnt;
    logic [2*W-1:0] acc;
    logic [BW-1:0]  sel;
    logic [2:0]     booth_bits;
    logic [W:0]     pp;
    logic           cpl;
    logic [2*W-1:0] pp_ext;
    logic [2*W-1:0] term;
    logic           accept;
    logic           issue;
    logic           stop_early;
    logic           last_issue;
    logic           em_valid;
    logic [IW-1:0]  em_idx;
    logic           head_busy;

    assign accept = (state == IDLE) && live && in_valid;
    assign issue  = (state == ISSUE);

    // b_ext = {b, 0}: bit 0 stands in for b[-1], so digit k is b_ext[2k+2:2k].
    assign sel        = BW'({cnt, 1'b0});
    assign booth_bits = b_ext[sel +: 3];

    booth_pp #(
        .W    (W),
        .PIPE (PIPE)
    ) u_pp (
        .clk        (clk),
        .rst        (rst),
        .y          (a_q),
        .booth_bits (booth_bits),
        .pp         (pp),
        .cpl        (cpl)
    );

`ifdef BOOTH_SEQ_EARLY_TERM_EN
    // Decided while issuing digit cnt: are b[W-1:2(cnt+1)-1] all sign copies?
    always_comb begin
        stop_early = 1'b1;
        for (int unsigned i = 0; i <= W; i++) begin
            if (i >= 2 * (32'(cnt) + 1) && b_ext[i] != b_ext[W]) stop_early = 1'b0;
        end
    end
`else
    assign stop_early = 1'b0;
`endif

    assign last_issue = (cnt == LAST) || stop_early;

    generate
        if (PIPE == 0) begin : g_trk0
            assign em_valid  = issue;
            assign em_idx    = cnt;
            assign head_busy = 1'b0;
        end else begin : g_trk
            logic          v_q   [PIPE];
            logic [IW-1:0] idx_q [PIPE];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int unsigned i = 0; i < PIPE; i++) begin
                        v_q[i]   <= 1'b0;
                        idx_q[i] <= '0;
                    end
                end else begin
                    v_q[0]   <= issue;
                    idx_q[0] <= cnt;
                    for (int unsigned i = 1; i < PIPE; i++) begin
                        v_q[i]   <= v_q[i-1];
                        idx_q[i] <= idx_q[i-1];
                    end
                end
            end
            // Only the tail entry may still be in flight on the DRAIN exit edge.
            always_comb begin
                head_busy = 1'b0;
                for (int unsigned i = 0; i + 1 < PIPE; i++) head_busy = head_busy | v_q[i];
            end
            assign em_valid = v_q[PIPE-1];
            assign em_idx   = idx_q[PIPE-1];
        end
    endgenerate

    assign pp_ext = {{(W-1){pp[W]}}, pp};
    assign term   = (pp_ext + {{(2*W-1){1'b0}}, cpl}) << {em_idx, 1'b0};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ISSUE;
            ISSUE:   if (last_issue) state_nx = (PIPE > 0) ? DRAIN : DONE;
            DRAIN:   if (!head_busy) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            live  <= 1'b0;
            a_q   <= '0;
            b_ext <= '0;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            state <= state_nx;
            live  <= 1'b1;
            if (accept) begin
                a_q   <= a;
                b_ext <= {b, 1'b0};
                cnt   <= '0;
                acc   <= '0;
            end else begin
                if (issue) cnt <= cnt + 1'b1;
                if (em_valid) acc <= acc + term;
            end
        end
    end

    assign in_ready  = (state == IDLE) && live;
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign product   = out_valid ? acc : '0;
endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed self-checking bench for booth_seq_mult: three instances (PIPE = 0, 1, 2), W = 8.
// Latency expectations follow BOOTH_SEQ_EARLY_TERM_EN when it is defined for the build.

module tb_booth_seq_mult;
`ifdef BOOTH_SEQ_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        iv  [3];
    logic        ir  [3];
    logic        ov  [3];
    logic        ordy[3];
    logic        bz  [3];
    logic [7:0]  a_s [3];
    logic [7:0]  b_s [3];
    logic [15:0] pr  [3];

    int n_assert = 0;
    int n_fail   = 0;

    booth_seq_mult #(.W(8), .PIPE(0)) u_p0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_s[0]), .b(b_s[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .product(pr[0]), .busy(bz[0])
    );
    booth_seq_mult #(.W(8), .PIPE(1)) u_p1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_s[1]), .b(b_s[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .product(pr[1]), .busy(bz[1])
    );
    booth_seq_mult #(.W(8), .PIPE(2)) u_p2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_s[2]), .b(b_s[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .product(pr[2]), .busy(bz[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with the instance idle; returns at posedge+1 after the output transfer.
    task automatic op(input int d, input logic [7:0] av, input logic [7:0] bv,
                      input logic [15:0] exp, input int lat, input int hold,
                      input bit chain, input logic [7:0] na, input logic [7:0] nb,
                      input string tag);
        int          n;
        bit          ok;
        logic [15:0] p0;
        chk({tag, "/in_ready_idle"}, 32'(ir[d]), 32'd1);
        a_s[d] = av;
        b_s[d] = bv;
        iv[d]  = 1'b1;
        @(posedge clk); #1;
        if (chain) begin
            a_s[d] = na;
            b_s[d] = nb;
        end else begin
            iv[d]  = 1'b0;
            a_s[d] = ~av;
            b_s[d] = ~bv;
        end
        n  = 1;
        ok = 1'b1;
        while (ov[d] !== 1'b1 && n < 40) begin
            if (bz[d] !== 1'b1 || ir[d] !== 1'b0) ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "/latency"}, 32'(n), 32'(lat));
        chk({tag, "/busy_noready"}, 32'(ok), 32'd1);
        chk({tag, "/product"}, 32'(pr[d]), 32'(exp));
        p0 = pr[d];
        ok = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
            if (ov[d] !== 1'b1 || pr[d] !== p0 || ir[d] !== 1'b0 || bz[d] !== 1'b1) ok = 1'b0;
        end
        if (hold > 0) chk({tag, "/stall_hold"}, 32'(ok), 32'd1);
        ordy[d] = 1'b1;
        @(posedge clk); #1;
        ordy[d] = 1'b0;
        chk({tag, "/out_valid_drop"}, 32'(ov[d]), 32'd0);
        chk({tag, "/in_ready_back"}, 32'(ir[d]), 32'd1);
    endtask

    initial begin
        bit ok;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            iv[d]   = 1'b0;
            ordy[d] = 1'b0;
            a_s[d]  = '0;
            b_s[d]  = '0;
        end
        #1;
        for (int d = 0; d < 3; d++)
            chk($sformatf("reset_outputs_%0d", d), {12'h0, ir[d], ov[d], bz[d], 1'b0, pr[d]}, 32'h0);

        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) chk($sformatf("in_ready_after_reset_%0d", d), 32'(ir[d]), 32'd1);

        // PIPE=0
        op(0, 8'h07, 8'hFD, 16'hFFEB, ET ? 3 : 5, 0, 1'b0, 8'h00, 8'h00, "p0_7xm3");
        op(0, 8'h05, 8'h06, 16'h001E, ET ? 3 : 5, 10, 1'b0, 8'h00, 8'h00, "p0_stall");
        chk("p0_single_transfer", 32'(ov[0]), 32'd0);
        op(0, 8'h00, 8'hAB, 16'h0000, 5, 0, 1'b1, 8'h03, 8'h04, "p0_zero_a");
        op(0, 8'h03, 8'h04, 16'h000C, ET ? 3 : 5, 0, 1'b0, 8'h00, 8'h00, "p0_held_valid");
        op(0, 8'h12, 8'h00, 16'h0000, ET ? 2 : 5, 0, 1'b0, 8'h00, 8'h00, "p0_zero_b");
        op(0, 8'h13, 8'h01, 16'h0013, ET ? 2 : 5, 0, 1'b0, 8'h00, 8'h00, "p0_b_one");
        op(0, 8'h13, 8'hFF, 16'hFFED, ET ? 2 : 5, 0, 1'b0, 8'h00, 8'h00, "p0_b_m1");

        // PIPE=2
        op(2, 8'h80, 8'h80, 16'h4000, 7, 0, 1'b0, 8'h00, 8'h00, "p2_minmin");
        op(2, 8'h7F, 8'h7F, 16'h3F01, 7, 0, 1'b0, 8'h00, 8'h00, "p2_maxmax");

        // PIPE=1: reset during the third ISSUE cycle
        chk("p1_in_ready_pre", 32'(ir[1]), 32'd1);
        a_s[1] = 8'h55;
        b_s[1] = 8'h33;
        iv[1]  = 1'b1;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("p1_midreset_outputs", {12'h0, ir[1], ov[1], bz[1], 1'b0, pr[1]}, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        ok = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (ov[1] !== 1'b0) ok = 1'b0;
        end
        chk("p1_no_out_valid_after_reset", 32'(ok), 32'd1);
        op(1, 8'hFF, 8'h02, 16'hFFFE, ET ? 4 : 6, 0, 1'b0, 8'h00, 8'h00, "p1_m1x2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
